// File: rtl/cnn_matrix_loader_if.sv
// Stream-in / bus-write bundle for the CNN matrix loader.
// slave = loader side, master = stream source and bus observer.
interface cnn_matrix_loader_if #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32
);
    localparam int BUS_WE_WIDTH = BUS_DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]     sDataIn;
    logic                      sValidIn;
    logic                      sLastIn;
    logic                      sReadyOut;
    logic [BUS_ADDR_WIDTH-1:0] addrOut;
    logic [BUS_WE_WIDTH-1:0]   wrEnOut;
    logic [BUS_DATA_WIDTH-1:0] wrDataOut;

    modport master (
        output sDataIn, sValidIn, sLastIn,
        input  sReadyOut, addrOut, wrEnOut, wrDataOut
    );

    modport slave (
        input  sDataIn, sValidIn, sLastIn,
        output sReadyOut, addrOut, wrEnOut, wrDataOut
    );
endinterface

// File: rtl/cnn_matrix_loader.sv
// Framed stream to bus-write loader for the CNN accelerator.
// Optional length checking: define CNN_LOADER_LEN_CHECK_EN.
module cnn_matrix_loader #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_SIZE       = 4096,
    parameter int NUM_CH         = 2,
    localparam int DIM_WIDTH     = $clog2(MAX_SIZE) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    cnn_matrix_loader_if.slave            bus,
    output logic [NUM_CH*2*DIM_WIDTH-1:0] dimsOut,
    output logic                          startOut,
    input  logic                          doneIn,
    output logic                          busyOut,
    output logic                          errorOut
);
    localparam int NUM_WORDS    = BUS_DATA_WIDTH / DATA_WIDTH;
    localparam int WE_WIDTH     = DATA_WIDTH / 8;
    localparam int BUS_WE_WIDTH = BUS_DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = 2 * DIM_WIDTH;
    localparam logic [BUS_ADDR_WIDTH-1:0] CH_STRIDE =
        BUS_ADDR_WIDTH'(MAX_SIZE * WE_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLS,
        S_ROWS,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [CH_W-1:0]               r_ch;
    logic [NUM_CH*2*DIM_WIDTH-1:0] r_dims;
    logic [IDX_W-1:0]              r_pack_idx;
    logic [BUS_DATA_WIDTH-1:0]     r_pack_data;
    logic [BUS_WE_WIDTH-1:0]       r_pack_we;
    logic [BUS_ADDR_WIDTH-1:0]     r_beat_addr;
    logic [BUS_ADDR_WIDTH-1:0]     r_addr;
    logic [BUS_WE_WIDTH-1:0]       r_wren;
    logic [BUS_DATA_WIDTH-1:0]     r_wdata;
    logic                          r_start;
    logic                          r_busy;
    logic                          r_error;

    logic                          w_fire;
    logic                          w_issue;
    logic                          w_err;
    logic                          w_last_ch;
    logic                          w_full;
    logic [BUS_DATA_WIDTH-1:0]     w_pack_data;
    logic [BUS_WE_WIDTH-1:0]       w_pack_we;
    logic [BUS_ADDR_WIDTH-1:0]     w_ch_base;

`ifdef CNN_LOADER_LEN_CHECK_EN
    logic [CNT_W-1:0]              r_count;
    logic [CNT_W-1:0]              r_total;
    logic [CNT_W-1:0]              w_count_next;
    logic [CNT_W-1:0]              w_prod;
    logic [DIM_WIDTH-1:0]          w_rows_in;
    logic [DIM_WIDTH-1:0]          w_cols_cur;
    logic                          w_bad_dims;

    assign w_rows_in    = bus.sDataIn[DIM_WIDTH-1:0];
    assign w_cols_cur   = r_dims[r_ch*2*DIM_WIDTH +: DIM_WIDTH];
    assign w_prod       = CNT_W'(w_rows_in) * CNT_W'(w_cols_cur);
    assign w_count_next = r_count + CNT_W'(1);
    assign w_bad_dims   = (w_rows_in == '0) || (w_cols_cur == '0) ||
                          (w_prod > CNT_W'(MAX_SIZE));
`endif

    assign bus.sReadyOut = (r_state == S_COLS) || (r_state == S_ROWS) ||
                           (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_fire    = bus.sValidIn && bus.sReadyOut;
    assign w_last_ch = (r_ch == CH_W'(NUM_CH - 1));
    assign w_full    = (r_pack_idx == IDX_W'(NUM_WORDS - 1));
    assign w_ch_base = BUS_ADDR_WIDTH'(r_ch) * CH_STRIDE;

    assign bus.addrOut   = r_addr;
    assign bus.wrEnOut   = r_wren;
    assign bus.wrDataOut = r_wdata;
    assign dimsOut       = r_dims;
    assign startOut      = r_start;
    assign busyOut       = r_busy;
    assign errorOut      = r_error;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state, beat packing and beat-issue / error decisions.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_err        = 1'b0;
        w_pack_data  = r_pack_data;
        w_pack_we    = r_pack_we;
        w_pack_data[r_pack_idx*DATA_WIDTH +: DATA_WIDTH] = bus.sDataIn;
        w_pack_we[r_pack_idx*WE_WIDTH +: WE_WIDTH]       = '1;
        case (r_state)
            S_IDLE: begin
                if (bus.sValidIn) w_state_next = S_COLS;
            end
            S_COLS: begin
                if (w_fire) w_state_next = S_ROWS;
            end
            S_ROWS: begin
                if (w_fire) begin
                    w_state_next = S_LOAD;
`ifdef CNN_LOADER_LEN_CHECK_EN
                    if (w_bad_dims) begin
                        w_err        = 1'b1;
                        w_state_next = S_DRAIN;
                    end
`endif
                end
            end
            S_LOAD: begin
                if (w_fire) begin
                    w_issue = w_full || bus.sLastIn;
                    if (bus.sLastIn)
                        w_state_next = w_last_ch ? S_START : S_COLS;
`ifdef CNN_LOADER_LEN_CHECK_EN
                    if (bus.sLastIn && (w_count_next != r_total)) begin
                        w_err        = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (!bus.sLastIn &&
                                 (w_count_next == r_total)) begin
                        w_err        = 1'b1;
                        w_issue      = 1'b1;
                        w_state_next = S_DRAIN;
                    end
`endif
                end
            end
            S_START: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done coinciding with the start pulse belongs to no job.
                if (doneIn && !r_start) w_state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (w_fire && bus.sLastIn) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: dims, packing, bus write registers, status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch        <= '0;
            r_dims      <= '0;
            r_pack_idx  <= '0;
            r_pack_data <= '0;
            r_pack_we   <= '0;
            r_beat_addr <= '0;
            r_addr      <= '0;
            r_wren      <= '0;
            r_wdata     <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
`ifdef CNN_LOADER_LEN_CHECK_EN
            r_count     <= '0;
            r_total     <= '0;
`endif
        end else begin
            r_wren  <= '0;
            r_start <= (r_state == S_START);
            r_busy  <= (w_state_next != S_IDLE);
            r_error <= r_error | w_err;
            case (r_state)
                S_IDLE: begin
                    if (w_state_next == S_COLS) r_ch <= '0;
                end
                S_COLS: begin
                    if (w_fire)
                        r_dims[r_ch*2*DIM_WIDTH +: DIM_WIDTH] <=
                            bus.sDataIn[DIM_WIDTH-1:0];
                end
                S_ROWS: begin
                    if (w_fire) begin
                        r_dims[r_ch*2*DIM_WIDTH+DIM_WIDTH +: DIM_WIDTH] <=
                            bus.sDataIn[DIM_WIDTH-1:0];
                        r_pack_idx  <= '0;
                        r_pack_data <= '0;
                        r_pack_we   <= '0;
                        r_beat_addr <= w_ch_base;
`ifdef CNN_LOADER_LEN_CHECK_EN
                        r_count     <= '0;
                        r_total     <= w_prod;
`endif
                    end
                end
                S_LOAD: begin
                    if (w_fire) begin
`ifdef CNN_LOADER_LEN_CHECK_EN
                        r_count <= w_count_next;
`endif
                        if (w_issue) begin
                            r_addr      <= r_beat_addr;
                            r_wren      <= w_pack_we;
                            r_wdata     <= w_pack_data;
                            r_beat_addr <= r_beat_addr +
                                BUS_ADDR_WIDTH'(BUS_WE_WIDTH);
                            r_pack_idx  <= '0;
                            r_pack_data <= '0;
                            r_pack_we   <= '0;
                        end else begin
                            r_pack_idx  <= r_pack_idx + IDX_W'(1);
                            r_pack_data <= w_pack_data;
                            r_pack_we   <= w_pack_we;
                        end
                        if (w_state_next == S_COLS)
                            r_ch <= r_ch + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cnn_matrix_loader.md
# cnn_matrix_loader

Synthesizable stream-to-bus loader for the CNN hardware accelerator. It takes one framed word stream carrying NUM_CH matrices per job: channel 0 is data, channels 1..NUM_CH-1 are filters. It packs the elements into bus-width writes with byte enables, places each channel in its own address region and latches per-channel dimensions. It pulses start once the last write lands and holds off the next job until the accelerator reports done.

## Interface
- BUS_ADDR_WIDTH, 32, bus address width.
- BUS_DATA_WIDTH, 64, bus write-data width; must be a multiple of DATA_WIDTH.
- DATA_WIDTH, 32, element and stream word width.
- MAX_SIZE, 4096, max rows*cols per channel.
- NUM_CH, 2, matrices per job (>=1).
- Derived:
  - NUM_WORDS = BUS_DATA_WIDTH/DATA_WIDTH.
  - WE_WIDTH = DATA_WIDTH/8.
  - BUS_WE_WIDTH = BUS_DATA_WIDTH/8.
  - DIM_WIDTH = clog2(MAX_SIZE)+1.
  - CH_STRIDE = MAX_SIZE*WE_WIDTH (bytes).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- sDataIn  in  DATA_WIDTH  stream word.
- sValidIn  in  1  stream word valid.
- sLastIn  in  1  final element of current matrix.
- sReadyOut  out  1  loader accepts word.
- addrOut  out  BUS_ADDR_WIDTH  write byte address.
- wrEnOut  out  BUS_WE_WIDTH  byte write enables; all-zero = no write.
- wrDataOut  out  BUS_DATA_WIDTH  write data.
- dimsOut  out  NUM_CH*2*DIM_WIDTH  per channel c: {rows,cols} at bits [c*2*DIM_WIDTH +: 2*DIM_WIDTH], cols in low half.
- startOut  out  1  one-cycle job start pulse.
- doneIn  in  1  accelerator finished current job.
- busyOut  out  1  job in progress.
- errorOut  out  1  sticky framing error.

## Operation
- Frame per channel: word 0 = cols, word 1 = rows, then rows*cols elements in row-major order. sLastIn is high on the final element.
- Handshake: a word transfers when sValidIn && sReadyOut. sReadyOut is high only in COLS, ROWS, LOAD, DRAIN.
- States:
  - IDLE: sReadyOut=0. On sValidIn go to COLS, ch=0, set busyOut.
  - COLS: accept cols into dimsOut[ch], go to ROWS.
  - ROWS: accept rows, clear the element count, pack index and beat address, go to LOAD.
  - LOAD: accept elements. Element j of beat k goes to wrDataOut bits [j*DATA_WIDTH +: DATA_WIDTH].
    - A beat issues when NUM_WORDS words are packed or on sLastIn.
    - A partial beat enables only the bytes of the words filled; unfilled data bits are 0.
    - Beat address = ch*CH_STRIDE + k*BUS_WE_WIDTH, k from 0.
    - On sLastIn: if ch<NUM_CH-1, ch++ and go to COLS; otherwise go to START.
  - START: pulse startOut, go to WAIT.
  - WAIT: on doneIn, clear busyOut and go to IDLE.
  - DRAIN: accept and discard words until sLastIn, then go to IDLE with no start.
- Element count width is DIM_WIDTH*2 with no wrap. rows*cols is computed once at ROWS.
- doneIn is ignored outside WAIT.

## Timing
- Reset values: sReadyOut 0, addrOut 0, wrEnOut 0, wrDataOut 0, dimsOut 0, startOut 0, busyOut 0, errorOut 0, state IDLE, ch 0.
- rst mid-job discards any partial beat; no write issues on the following cycle.
- IDLE->COLS costs one bubble cycle; the first word is accepted no earlier than the cycle after sValidIn is seen in IDLE.
- Write latency: wrEnOut/addrOut/wrDataOut are registered and valid for exactly one cycle, the cycle after the handshake that completes the beat.
- wrEnOut is zero on every other cycle.
- Stream stalls (sValidIn low) insert no writes and lose no data.
- startOut asserts the cycle after the final beat's write cycle; it never coincides with a write.
- dimsOut[c] updates the cycle after its header word handshake and holds until overwritten.
- doneIn arriving in the same cycle as startOut is ignored; it must arrive in WAIT.

## Configuration
- CNN_LOADER_LEN_CHECK_EN defined:
  - At ROWS, rows==0, cols==0 or rows*cols>MAX_SIZE sets errorOut and goes to DRAIN.
  - In LOAD, sLastIn before count==rows*cols sets errorOut and aborts to IDLE; the partial beat is still written.
  - In LOAD, count reaching rows*cols without sLastIn sets errorOut and goes to DRAIN.
  - errorOut clears only on rst.
- Not defined:
  - sLastIn alone terminates each matrix; dimensions are not checked.
  - errorOut is tied 0 and DRAIN is unreachable.

## Test plan
- Defaults, data 2x3 elements 1..6, filter 3x3 elements 11..19:
  - Three data writes at 0x0, 0x8, 0x10 with wrEnOut=0xFF.
  - Five filter writes from 0x4000, the last at 0x4020 with wrEnOut=0x0F and data 0x13 in the low word.
  - startOut one cycle after that write.
  - dimsOut shows cols 3/rows 2 and cols 3/rows 3.
- Same job with sValidIn toggled every other cycle: identical write sequence, no extra wrEnOut cycles.
- doneIn pulsed at the startOut cycle, then 5 cycles later: busyOut stays high until the second pulse; a new frame is not accepted before it.
- With CNN_LOADER_LEN_CHECK_EN, data 2x2 with sLastIn on element 3: errorOut=1, one 0xFF write and one 0x0F write, no startOut.
- With CNN_LOADER_LEN_CHECK_EN, header cols=128, rows=64 (8192>4096): errorOut=1, words drained to sLastIn, zero writes.
- rst asserted after 3 data elements: all outputs return to reset values next cycle; a fresh job then loads correctly from address 0x0.
